// File: rtl/mux4_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// mux4_scan_ctrl_if
// Signal bundle between the scan controller, its requester, the 4:1 mux and
// the downstream consumer of the assembled word.
//
// Request side : start, mask[3:0], cont
// Mux side     : mux_out (in to controller), s1/s0 (select, out)
// Result side  : data[3:0], valid (out), ready (in)
// Status       : busy, state_dbg[1:0] (current FSM state, for observation)
//
// Handshake: a word transfers on every rising clock edge where valid and
// ready are both 1. valid, once raised, stays high with data stable until
// that edge; ready may be high or low at any time and is ignored while
// valid is low.
//
// Modports: slave = the scan controller, master = the environment driving it.
// ---------------------------------------------------------------------------
interface mux4_scan_ctrl_if;
  logic       start;
  logic [3:0] mask;
  logic       cont;
  logic       mux_out;
  logic       s1;
  logic       s0;
  logic       busy;
  logic [3:0] data;
  logic       valid;
  logic       ready;
  logic [1:0] state_dbg;

  modport slave (
    input  start, mask, cont, mux_out, ready,
    output s1, s0, busy, data, valid, state_dbg
  );

  modport master (
    output start, mask, cont, mux_out, ready,
    input  s1, s0, busy, data, valid, state_dbg
  );
endinterface

// File: rtl/mux4_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux4_scan_ctrl
// Steps the select lines of a 4:1 mux through the enabled channels, holds
// each for DWELL cycles, samples the mux output on the last edge of each
// window and presents the collected 4-bit word over valid/ready.
// Single-shot (cont=0) or continuous (cont=1) operation.
//
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : mux4_scan_ctrl_if.slave (start/mask/cont request, mux_out,
//            s1/s0 select, busy, data/valid/ready result, state_dbg)
// Parameter:
//   DWELL  : cycles each select is held before sampling, 1..255
// ---------------------------------------------------------------------------
module mux4_scan_ctrl #(
  parameter int unsigned DWELL = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  mux4_scan_ctrl_if.slave       bus
);

  localparam logic [7:0] LP_DWELL = 8'(DWELL);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_mask;
  logic [7:0] r_cnt;
  logic [1:0] r_ch;
  logic [3:0] r_collect;
  logic [3:0] r_data;
  logic       r_valid;

  // Lowest enabled channel at or above 'from'; returns 4 when none exists,
  // so bit 2 doubles as a "no more channels" flag.
  function automatic logic [2:0] f_find(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] res;
    res = 3'd4;
    for (int k = 3; k >= 0; k--) begin
      if (k >= int'(from) && m[k]) res = 3'(k);
    end
    return res;
  endfunction

  logic [2:0] w_first_req;
  logic [2:0] w_first_latched;
  logic [2:0] w_next;
  logic [3:0] w_onehot;
  logic [3:0] w_col;

  assign w_first_req     = f_find(bus.mask, 3'd0);
  assign w_first_latched = f_find(r_mask, 3'd0);
  assign w_next          = f_find(r_mask, {1'b0, r_ch} + 3'd1);
  assign w_onehot        = 4'b0001 << r_ch;
  // Collected word including the sample taken on this edge.
  assign w_col           = bus.mux_out ? (r_collect | w_onehot) : r_collect;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_mask    <= 4'd0;
      r_cnt     <= 8'd0;
      r_ch      <= 2'd0;
      r_collect <= 4'd0;
      r_data    <= 4'd0;
      r_valid   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && (bus.mask != 4'd0)) begin
            r_mask    <= bus.mask;
            r_cnt     <= LP_DWELL;
            r_ch      <= w_first_req[1:0];
            r_collect <= 4'd0;
            r_state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (r_cnt == 8'd1) begin
            if (w_next[2]) begin
              // Last enabled channel: publish the word on this same edge.
              r_data  <= w_col;
              r_valid <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_ch      <= w_next[1:0];
              r_cnt     <= LP_DWELL;
              r_collect <= w_col;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_DONE: begin
          if (r_valid && bus.ready) begin
            r_valid <= 1'b0;
            if (bus.cont) begin
              r_ch      <= w_first_latched[1:0];
              r_cnt     <= LP_DWELL;
              r_collect <= 4'd0;
              r_state   <= ST_SCAN;
            end else begin
              r_ch    <= 2'd0;
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s1        = r_ch[1];
  assign bus.s0        = r_ch[0];
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux4_scan_ctrl
// Two controller instances: u_dut1 with DWELL=2 and u_dut2 with DWELL=1.
// Each mux is modelled as in_bits[{s1,s0}]. Per-cycle vectors cover the
// full and partial scans; hand-written sequences cover reset, backpressure,
// continuous mode and reset in the middle of a scan.
// ---------------------------------------------------------------------------
module tb_mux4_scan_ctrl;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [3:0] in1;
  logic [3:0] in2;

  mux4_scan_ctrl_if u_if1 ();
  mux4_scan_ctrl_if u_if2 ();

  mux4_scan_ctrl #(.DWELL(2)) u_dut1 (.clock(clock), .reset(reset), .bus(u_if1.slave));
  mux4_scan_ctrl #(.DWELL(1)) u_dut2 (.clock(clock), .reset(reset), .bus(u_if2.slave));

  assign u_if1.mux_out = in1[{u_if1.s1, u_if1.s0}];
  assign u_if2.mux_out = in2[{u_if2.s1, u_if2.s0}];

  // ---- clock ----
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---- vector table ----
  typedef struct packed {
    logic       start;
    logic [3:0] mask;
    logic       ready;
    logic [3:0] in_bits;
    logic [1:0] sel;
    logic       busy;
    logic       valid;
    logic [3:0] data;
  } vec_t;

  localparam int NV = 18;
  vec_t vec [NV];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] obs1();
    return {u_if1.s1, u_if1.s0, u_if1.busy, u_if1.valid, u_if1.data};
  endfunction

  function automatic logic [7:0] obs2();
    return {u_if2.s1, u_if2.s0, u_if2.busy, u_if2.valid, u_if2.data};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Full scan, DWELL=2, inputs i0..i3 = 1,0,1,0, mask 1111
    vec[0]  = '{1'b1, 4'hF, 1'b0, 4'b0101, 2'd0, 1'b1, 1'b0, 4'h0};
    vec[1]  = '{1'b0, 4'hF, 1'b0, 4'b0101, 2'd0, 1'b1, 1'b0, 4'h0};
    vec[2]  = '{1'b0, 4'hF, 1'b0, 4'b0101, 2'd1, 1'b1, 1'b0, 4'h0};
    vec[3]  = '{1'b0, 4'hF, 1'b0, 4'b0101, 2'd1, 1'b1, 1'b0, 4'h0};
    vec[4]  = '{1'b0, 4'hF, 1'b0, 4'b0101, 2'd2, 1'b1, 1'b0, 4'h0};
    vec[5]  = '{1'b0, 4'hF, 1'b0, 4'b0101, 2'd2, 1'b1, 1'b0, 4'h0};
    vec[6]  = '{1'b0, 4'hF, 1'b0, 4'b0101, 2'd3, 1'b1, 1'b0, 4'h0};
    vec[7]  = '{1'b0, 4'hF, 1'b1, 4'b0101, 2'd3, 1'b1, 1'b0, 4'h0};
    vec[8]  = '{1'b0, 4'hF, 1'b1, 4'b0101, 2'd3, 1'b1, 1'b1, 4'b0101};
    vec[9]  = '{1'b0, 4'hF, 1'b1, 4'b0101, 2'd0, 1'b0, 1'b0, 4'b0101};
    // Partial mask 1010, inputs 1,1,1,1; ready already high as valid rises
    vec[10] = '{1'b1, 4'hA, 1'b0, 4'b1111, 2'd1, 1'b1, 1'b0, 4'b0101};
    vec[11] = '{1'b0, 4'hA, 1'b0, 4'b1111, 2'd1, 1'b1, 1'b0, 4'b0101};
    vec[12] = '{1'b0, 4'hA, 1'b0, 4'b1111, 2'd3, 1'b1, 1'b0, 4'b0101};
    vec[13] = '{1'b0, 4'hA, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b0, 4'b0101};
    vec[14] = '{1'b0, 4'hA, 1'b1, 4'b1111, 2'd3, 1'b1, 1'b1, 4'b1010};
    vec[15] = '{1'b0, 4'hA, 1'b1, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b1010};
    // start with mask 0 is ignored
    vec[16] = '{1'b1, 4'h0, 1'b0, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b1010};
    vec[17] = '{1'b0, 4'h0, 1'b0, 4'b1111, 2'd0, 1'b0, 1'b0, 4'b1010};

    u_if1.start = 1'b0; u_if1.mask = 4'h0; u_if1.cont = 1'b0; u_if1.ready = 1'b0;
    u_if2.start = 1'b0; u_if2.mask = 4'h0; u_if2.cont = 1'b0; u_if2.ready = 1'b0;
    in1 = 4'h0;
    in2 = 4'h0;

    // ---- reset: asserted mid-cycle, then idle for 3 cycles ----
    reset = 1'b1;
    #3 reset = 1'b0;
    #1;
    check("reset_dut1", obs1(), 8'h00);
    check("reset_dut2", obs2(), 8'h00);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle%0d", i), obs1(), 8'h00);
    end

    // ---- table-driven full and partial scans on u_dut1 ----
    for (int i = 0; i < NV; i++) begin
      u_if1.start = vec[i].start;
      u_if1.mask  = vec[i].mask;
      u_if1.ready = vec[i].ready;
      in1         = vec[i].in_bits;
      tick();
      check($sformatf("vec%0d", i), obs1(),
            {vec[i].sel, vec[i].busy, vec[i].valid, vec[i].data});
    end
    u_if1.start = 1'b0;
    u_if1.ready = 1'b0;

    // ---- backpressure ----
    in1 = 4'b1111;
    u_if1.mask  = 4'hF;
    u_if1.start = 1'b1;
    tick();
    u_if1.start = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    tick();
    check("bp_valid", obs1(), {2'd3, 1'b1, 1'b1, 4'hF});
    for (int i = 0; i < 5; i++) begin
      u_if1.start = (i % 2 == 0);
      u_if1.mask  = 4'b0011;
      tick();
      check($sformatf("bp_hold%0d", i), obs1(), {2'd3, 1'b1, 1'b1, 4'hF});
    end
    u_if1.start = 1'b0;
    u_if1.ready = 1'b1;
    tick();
    check("bp_release", obs1(), {2'd0, 1'b0, 1'b0, 4'hF});
    check("bp_state", {6'd0, u_if1.state_dbg}, 8'd0);
    u_if1.ready = 1'b0;

    // ---- continuous mode on u_dut2 (DWELL=1) ----
    in2 = 4'b0101;
    u_if2.mask  = 4'hF;
    u_if2.cont  = 1'b1;
    u_if2.ready = 1'b1;
    u_if2.start = 1'b1;
    tick();
    u_if2.start = 1'b0;
    for (int off = 1; off <= 19; off++) begin
      tick();
      check($sformatf("cont_valid%0d", off), {7'd0, u_if2.valid}, {7'd0, (off % 5 == 4)});
      if (off % 5 == 4)
        check($sformatf("cont_data%0d", off), {4'd0, u_if2.data},
              {4'd0, (off == 19) ? 4'b1010 : 4'b0101});
      if (off == 14) in2 = 4'b1010;
    end
    u_if2.cont = 1'b0;

    // ---- reset mid-scan on u_dut1 ----
    in1 = 4'b0001;
    u_if1.mask  = 4'hF;
    u_if1.start = 1'b1;
    tick();
    u_if1.start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    check("mid_sel10", obs1(), {2'd2, 1'b1, 1'b0, 4'hF});
    #2 reset = 1'b0;
    #1;
    check("mid_reset", obs1(), 8'h00);
    @(negedge clock);
    reset = 1'b1;
    u_if1.mask  = 4'b0001;
    u_if1.start = 1'b1;
    tick();
    u_if1.start = 1'b0;
    check("post_e0", obs1(), {2'd0, 1'b1, 1'b0, 4'h0});
    tick();
    check("post_e1", obs1(), {2'd0, 1'b1, 1'b0, 4'h0});
    tick();
    check("post_e2", obs1(), {2'd0, 1'b1, 1'b1, 4'b0001});
    u_if1.ready = 1'b1;
    tick();
    check("post_ack", obs1(), {2'd0, 1'b0, 1'b0, 4'b0001});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux4_scan_ctrl.md
# mux4_scan_ctrl

Sequential scan controller that sits directly upstream of the 4-to-1 gate-level multiplexer (`mux4_to_1`). It drives the mux select lines `s1`/`s0` through the enabled input channels, holds each selection for a programmable dwell time, and samples the mux output at the end of each dwell window. The sampled bits are assembled into a 4-bit word, which is presented downstream through a valid/ready handshake. The block supports single-shot and continuous scan modes.

## Interface
- `DWELL`, default 2: cycles each channel select is held before its sample is taken; legal range 1..255.
- `clock`  in  1  single clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle scan request; accepted only in IDLE.
- `mask`  in  4  channel enables, bit k = channel k; captured when `start` is accepted.
- `cont`  in  1  continuous mode; sampled at each handshake edge.
- `mux_out`  in  1  output of the 4:1 mux; synchronous to `clock`.
- `s1`, `s0`  out  1 each  mux select lines, channel = {s1,s0}.
- `busy`  out  1  high whenever state is not IDLE.
- `data`  out  4  assembled word; bit k = sample taken from channel k.
- `valid`  out  1  `data` is available.
- `ready`  in  1  downstream accepts `data`.

## Operation
- Reset values: `s1`=`s0`=0, `busy`=0, `valid`=0, `data`=0.
- State machine: IDLE, SCAN, DONE.
- IDLE:
  - `start`=1 with `mask`≠0: latch `mask`, load the dwell counter with DWELL, drive the select to the lowest enabled channel, go to SCAN.
  - `start` with `mask`=0 is ignored.
- SCAN:
  - The select is held for exactly DWELL cycles per channel.
  - On the last edge of the window, `mux_out` is sampled into collect bit k.
  - Then the select moves to the next higher enabled channel and the counter reloads.
  - Disabled channels are never driven and their data bits read 0.
  - After the last enabled channel's sample, load `data` (including that bit), assert `valid`, and go to DONE, all on the same edge.
- DONE:
  - `data`, `valid`, `s1` and `s0` are held; the select stays on the last channel.
  - The handshake completes on an edge where `valid`&`ready`=1. At that edge `valid` drops.
  - If `cont`=1, a new scan starts with the latched mask on the same edge: select = lowest enabled channel, state = SCAN.
  - Otherwise the state returns to IDLE and the select returns to 00.
- `start` outside IDLE is ignored; `ready` without `valid` has no effect.
- The collect register clears at every scan start, so stale bits never leak into a new word.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously). Partial data and the latched mask are discarded.

## Timing
- Let E0 be the edge that accepts `start`. The select for the first channel is valid immediately after E0.
- Channel j (0-based in the enabled order) is sampled at edge E0+(j+1)·DWELL.
- `valid` rises at E0+N·DWELL, where N = popcount(mask). For example, DWELL=2 and N=4 gives 8 cycles.
- Minimum handshake: `valid` is seen high for one cycle and accepted at the next edge, even if `ready` was already high when `valid` rose.
- Continuous mode with `ready` held at 1: one word every N·DWELL+1 cycles.
- The select changes only on clock edges, never mid-cycle. `data` changes only on the edge that asserts `valid`.

## Test plan
- **Reset:** assert `reset`=0 mid-cycle -> all outputs immediately 0. Release reset, hold for 3 cycles with no `start` -> outputs stay 0, `busy`=0.
- **Full scan:**
  - Setup: DWELL=2, mux inputs i0..i3 = 1,0,1,0, `mask`=4'b1111, `start` pulse.
  - Required select sequence: 00,00,01,01,10,10,11,11.
  - Required result: `valid` high at E0+8 with `data`=4'b0101, `busy`=1 throughout.
- **Partial mask:**
  - Setup: `mask`=4'b1010, inputs 1,1,1,1.
  - Required select sequence: only 01 (2 cycles) then 11 (2 cycles).
  - Required result: `valid` at E0+4 with `data`=4'b1010. A `start` with `mask`=0 leaves the block in IDLE.
- **Backpressure:**
  - Hold `ready`=0 for 5 cycles after `valid`, pulsing `start` during that time -> `data`/`valid`/select stable, no new scan.
  - Raise `ready` -> `valid` falls at the next edge and the state returns to IDLE (`cont`=0).
- **Continuous:**
  - Setup: DWELL=1, `mask`=4'b1111, `cont`=1, `ready` tied to 1 -> `valid` pulses every 5 cycles.
  - Flip inputs to 0,1,0,1 mid-stream -> the next complete word is 4'b1010.
- **Reset mid-scan:** assert reset while the select = 10 -> outputs drop to 0 asynchronously. After release, a new `start` with `mask`=4'b0001 and i0=1 -> `data`=4'b0001 at E0+DWELL.
